// File: rtl/multi_freq_counter_pkg.sv
// Shared FSM state type and default sizing for the multi-channel frequency counter.
// Count overflow behaviour is selected by FREQ_COUNTER_SATURATE_EN (see multi_freq_counter.sv).
package multi_freq_counter_pkg;

    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_CNTR_SIZE = 16;
    localparam int DEF_GATE_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector for one measured input.
// The edge_det pulse lags a meas_in rise by 3 clk_ref cycles. Independent of FREQ_COUNTER_SATURATE_EN.
module edge_sync (
    input  logic clk_ref,
    input  logic rst,
    input  logic meas_in,
    output logic edge_det
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            edge_det <= 1'b0;
        end else begin
            sync1    <= meas_in;
            sync2    <= sync1;
            prev     <= sync2;
            edge_det <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/multi_freq_counter.sv
// Gated multi-channel edge counter: counts rising edges per channel over a gate window of gate_len cycles.
// FREQ_COUNTER_SATURATE_EN defined: counts saturate at all-ones; undefined: counts wrap. ovf is set either way.
module multi_freq_counter
    import multi_freq_counter_pkg::*;
#(
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int CNTR_SIZE = DEF_CNTR_SIZE,
    parameter int GATE_SIZE = DEF_GATE_SIZE
) (
    input  logic                          clk_ref,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           meas_in,
    input  logic                          start,
    input  logic                          continuous,
    input  logic [GATE_SIZE-1:0]          gate_len,
    output logic                          busy,
    output logic [CHANNELS*CNTR_SIZE-1:0] freq,
    output logic [CHANNELS-1:0]           ovf,
    output logic                          valid
);

    logic [CHANNELS-1:0]  edge_det;
    state_t               state;
    logic [GATE_SIZE-1:0] gate_left;
    logic [GATE_SIZE-1:0] gate_eff;
    logic [CNTR_SIZE-1:0] cnt [CHANNELS];
    logic [CHANNELS-1:0]  acc;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        edge_sync u_edge_sync (
            .clk_ref  (clk_ref),
            .rst      (rst),
            .meas_in  (meas_in[g]),
            .edge_det (edge_det[g])
        );
    end

    always_comb begin
        gate_eff = gate_len;
        if (gate_len == '0) begin
            gate_eff = GATE_SIZE'(1);
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gate_left <= '0;
            valid     <= 1'b0;
            freq      <= '0;
            ovf       <= '0;
            acc       <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || continuous) begin
                        state     <= GATE;
                        gate_left <= gate_eff;
                    end
                end
                GATE: begin
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        if (edge_det[i]) begin
                            if (cnt[i] == '1) begin
                                acc[i] <= 1'b1;
                            end
`ifdef FREQ_COUNTER_SATURATE_EN
                            if (cnt[i] != '1) begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
`else
                            cnt[i] <= cnt[i] + 1'b1;
`endif
                        end
                    end
                    // gate_left counts down the remaining GATE cycles, including this one
                    if (gate_left == GATE_SIZE'(1)) begin
                        state <= LATCH;
                    end else begin
                        gate_left <= gate_left - 1'b1;
                    end
                end
                LATCH: begin
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        freq[i*CNTR_SIZE +: CNTR_SIZE] <= cnt[i];
                        cnt[i] <= '0;
                    end
                    ovf   <= acc;
                    acc   <= '0;
                    valid <= 1'b1;
                    if (continuous) begin
                        state     <= GATE;
                        gate_left <= gate_eff;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/multi_freq_counter.md
MULTI_FREQ_COUNTER -- requirements
Module: multi_freq_counter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent measured inputs.
REQ-002 SHALL have parameter CNTR_SIZE, default 16, width of each per-channel edge count.
REQ-003 SHALL have parameter GATE_SIZE, default 16, width of the gate-length input.
REQ-004 SHALL have port clk_ref  in  1  sole clock, rising-edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port meas_in  in  CHANNELS  asynchronous measured signals, one bit per channel.
REQ-007 SHALL have port start  in  1  single-cycle request to run one gate window.
REQ-008 SHALL have port continuous  in  1  high = back-to-back gate windows.
REQ-009 SHALL have port gate_len  in  GATE_SIZE  gate window length in clk_ref cycles.
REQ-010 SHALL have port busy  out  1  high while state is not IDLE.
REQ-011 SHALL have port freq  out  CHANNELS*CNTR_SIZE  latched counts, channel i at [i*CNTR_SIZE +: CNTR_SIZE].
REQ-012 SHALL have port ovf  out  CHANNELS  per-channel overflow of the latched count.
REQ-013 SHALL have port valid  out  1  one-cycle pulse when freq/ovf update.

Function
REQ-014 Each meas_in bit SHALL pass a 2-flop synchronizer, then a registered rising-edge detector; detection latency 3 clk_ref cycles.
REQ-015 FSM states SHALL be IDLE, GATE, LATCH.
REQ-016 IDLE -> GATE when start=1 or continuous=1; otherwise stay.
REQ-017 On entering GATE, gate_len SHALL be captured; gate_len=0 SHALL be treated as 1; later changes ignored until next window.
REQ-018 GATE SHALL last exactly max(gate_len,1) cycles, then -> LATCH.
REQ-019 Per-channel counter SHALL increment by 1 for each detected edge in a GATE cycle; edges in IDLE/LATCH are not counted.
REQ-020 Counter increment from all-ones SHALL set that channel's overflow accumulator; behaviour of count per REQ-031/032.
REQ-021 LATCH SHALL last one cycle; at its end freq<=counts, ovf<=accumulators, valid=1 for the next cycle only, counters/accumulators cleared.
REQ-022 LATCH -> GATE if continuous=1 at that cycle, else -> IDLE; dead time between windows is exactly 1 cycle.
REQ-023 start while busy=1 SHALL be ignored; start and continuous together in IDLE give one GATE entry.
REQ-024 continuous deasserted mid-window: current window completes and reports, then IDLE.
REQ-025 freq/ovf SHALL hold their value between valid pulses.
REQ-026 Exact counts guaranteed only for meas_in high and low times each >= 2 clk_ref cycles; faster inputs undercount, no error flagged.

Reset
REQ-027 rst=0 SHALL asynchronously force state IDLE, busy=0, valid=0, freq=0, ovf=0, counters, accumulators and synchronizer flops 0.
REQ-028 Reset mid-GATE SHALL abort the window with no valid pulse.
REQ-029 A meas_in held high across reset release SHALL produce one detected edge 3 cycles after release, counted only if in GATE.

Configuration
REQ-030 Macro FREQ_COUNTER_SATURATE_EN SHALL select count overflow behaviour.
REQ-031 Defined: counter saturates at all-ones; ovf still set.
REQ-032 Undefined: counter wraps modulo 2^CNTR_SIZE; ovf still set.

Structure
REQ-033 Package multi_freq_counter_pkg SHALL hold the FSM state typedef and default parameter constants.
REQ-034 Sub-module edge_sync (2-flop sync + rising-edge detect, rst/clk_ref) SHALL be instantiated once per channel.

Verification (CHANNELS=2, CNTR_SIZE=8, GATE_SIZE=8 unless stated)
REQ-035 gate_len=100, ch0 period 10, ch1 period 4, start pulse -> valid once 101 cycles after GATE entry, freq ch0=10, ch1=25, ovf=0.
REQ-036 CNTR_SIZE=4, gate_len=100, ch0 period 4 -> ovf[0]=1; ch0=15 with FREQ_COUNTER_SATURATE_EN, 9 without.
REQ-037 continuous=1, gate_len=20 -> valid every 21 cycles; deassert mid-window -> one further valid, then busy=0.
REQ-038 gate_len=0, start -> GATE one cycle, valid 2 cycles after GATE entry.
REQ-039 rst=0 at GATE cycle 50 -> all outputs 0 immediately, no valid; start during busy -> no second window.
